// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer capturing CDB results and answering operand lookups.
// Ports: clk/reset (async, active-high); alloc_req/alloc_rd -> alloc_ready/alloc_tag (tag = tail+1);
//   cdb_data {tag[37:32], value[31:0]}, tag 0 idle; lookup_tagN -> lookup_validN/lookup_valueN (combinational);
//   commit_en/commit_rd/commit_value/commit_tag and count are registered.
// Optional: define ROB_CDB_BYPASS_EN to let lookups see the CDB value in the cycle it is broadcast.
module reorder_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_req,
  input  logic [4:0]  alloc_rd,
  output logic        alloc_ready,
  output logic [5:0]  alloc_tag,
  input  logic [37:0] cdb_data,
  input  logic [5:0]  lookup_tag1,
  output logic        lookup_valid1,
  output logic [31:0] lookup_value1,
  input  logic [5:0]  lookup_tag2,
  output logic        lookup_valid2,
  output logic [31:0] lookup_value2,
  output logic        commit_en,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_value,
  output logic [5:0]  commit_tag,
  output logic [5:0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head, tail;
  logic [DEPTH-1:0] busy, done, hit1, hit2;
  logic [4:0] rd_a [DEPTH];
  logic [31:0] val_a [DEPTH];
  logic [31:0] acc1 [DEPTH+1];
  logic [31:0] acc2 [DEPTH+1];
  logic do_alloc, retire;
  assign alloc_ready = count < 6'(DEPTH);
  assign alloc_tag = 6'(tail) + 6'd1;
  assign do_alloc = alloc_req && alloc_ready;
  assign retire = busy[head] && done[head];
  assign acc1[0] = '0;
  assign acc2[0] = '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [5:0] TAG = 6'(i + 1);
    localparam logic [AW-1:0] IDX = AW'(i);
    logic b, d, byp;
    logic [4:0] r;
    logic [31:0] v, lv;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        b <= 1'b0;
        d <= 1'b0;
        r <= '0;
        v <= '0;
      end else if (do_alloc && tail == IDX) begin
        b <= 1'b1;
        d <= 1'b0;
        r <= alloc_rd;
      end else begin
        if (cdb_data[37:32] == TAG && b && !d) begin
          d <= 1'b1;
          v <= cdb_data[31:0];
        end
        if (retire && head == IDX) b <= 1'b0;
      end
    assign busy[i] = b;
    assign done[i] = d;
    assign rd_a[i] = r;
    assign val_a[i] = v;
`ifdef ROB_CDB_BYPASS_EN
    assign byp = cdb_data[37:32] == TAG;
`else
    assign byp = 1'b0;
`endif
    // a stored value always wins over a (ignored) repeat broadcast of a done tag
    assign lv = d ? v : cdb_data[31:0];
    assign hit1[i] = lookup_tag1 == TAG && b && (d || byp);
    assign hit2[i] = lookup_tag2 == TAG && b && (d || byp);
    assign acc1[i+1] = acc1[i] | (hit1[i] ? lv : 32'd0);
    assign acc2[i+1] = acc2[i] | (hit2[i] ? lv : 32'd0);
  end
  assign lookup_valid1 = |hit1;
  assign lookup_valid2 = |hit2;
  assign lookup_value1 = acc1[DEPTH];
  assign lookup_value2 = acc2[DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      commit_en <= 1'b0;
      commit_rd <= '0;
      commit_value <= '0;
      commit_tag <= '0;
    end else begin
      if (do_alloc) tail <= tail == AW'(DEPTH - 1) ? '0 : tail + 1'b1;
      if (retire) head <= head == AW'(DEPTH - 1) ? '0 : head + 1'b1;
      count <= do_alloc && !retire ? count + 6'd1 : !do_alloc && retire ? count - 6'd1 : count;
      commit_en <= retire;
      if (retire) begin
        commit_rd <= rd_a[head];
        commit_value <= val_a[head];
        commit_tag <= 6'(head) + 6'd1;
      end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized scoreboard bench for reorder_buffer against a tag-indexed program-order model.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  logic clk = 0, reset = 1, alloc_req = 0;
  logic [4:0] alloc_rd = 0;
  logic alloc_ready;
  logic [5:0] alloc_tag;
  logic [37:0] cdb_data = 0;
  logic [5:0] lookup_tag1 = 0, lookup_tag2 = 0;
  logic lookup_valid1, lookup_valid2, commit_en;
  logic [31:0] lookup_value1, lookup_value2, commit_value;
  logic [4:0] commit_rd;
  logic [5:0] commit_tag, count;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag), .cdb_data(cdb_data),
    .lookup_tag1(lookup_tag1), .lookup_valid1(lookup_valid1), .lookup_value1(lookup_value1),
    .lookup_tag2(lookup_tag2), .lookup_valid2(lookup_valid2), .lookup_value2(lookup_value2),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_value(commit_value),
    .commit_tag(commit_tag), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  typedef struct {logic [4:0] rd; logic [31:0] val; logic [5:0] tag;} commit_t;
  commit_t exp_q[$];
  int order[$];
  bit m_busy[64];
  bit m_done[64];
  logic [31:0] m_val[64];
  logic [4:0] m_rd[64];
  int m_next = 1;

  task automatic chk(string n, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, req, $time);
    end
  endtask

  function automatic void m_reset();
    order.delete();
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
    end
    m_next = 1;
  endfunction

  function automatic logic [32:0] m_lookup(int t);
    if (t >= 1 && t <= DEPTH && m_busy[t]) begin
      if (m_done[t]) return {1'b1, m_val[t]};
`ifdef ROB_CDB_BYPASS_EN
      if (int'(cdb_data[37:32]) == t) return {1'b1, cdb_data[31:0]};
`endif
    end
    return 33'd0;
  endfunction

  // advance the model across one clock edge using the inputs currently driven
  function automatic void m_edge();
    int ct = int'(cdb_data[37:32]);
    bit can_alloc = order.size() < DEPTH;
    if (order.size() > 0 && m_done[order[0]]) begin
      exp_q.push_back('{m_rd[order[0]], m_val[order[0]], 6'(order[0])});
      m_busy[order[0]] = 0;
      void'(order.pop_front());
    end
    if (ct >= 1 && ct <= DEPTH && m_busy[ct] && !m_done[ct]) begin
      m_done[ct] = 1;
      m_val[ct] = cdb_data[31:0];
    end
    if (alloc_req && can_alloc) begin
      m_busy[m_next] = 1;
      m_done[m_next] = 0;
      m_rd[m_next] = alloc_rd;
      order.push_back(m_next);
      m_next = m_next == DEPTH ? 1 : m_next + 1;
    end
  endfunction

  always @(negedge clk) begin
    commit_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("commit_en", commit_en, 1);
      chk("commit_rd", commit_rd, e.rd);
      chk("commit_value", commit_value, e.val);
      chk("commit_tag", commit_tag, e.tag);
    end else chk("commit_idle", commit_en, 0);
  end

  task automatic cyc(bit req, logic [4:0] rd, logic [5:0] ct, logic [31:0] cv, logic [5:0] l1, logic [5:0] l2);
    @(negedge clk);
    #1;
    alloc_req = req;
    alloc_rd = rd;
    cdb_data = {ct, cv};
    lookup_tag1 = l1;
    lookup_tag2 = l2;
    #1;
    chk("lookup1", {lookup_valid1, lookup_value1}, m_lookup(int'(l1)));
    chk("lookup2", {lookup_valid2, lookup_value2}, m_lookup(int'(l2)));
    chk("alloc_ready", alloc_ready, order.size() < DEPTH);
    chk("alloc_tag", alloc_tag, m_next);
    m_edge();
    @(posedge clk);
    #1;
    chk("count", count, order.size());
  endtask

  task automatic idle(int n, logic [5:0] l1 = 0);
    repeat (n) cyc(0, 0, 0, 0, l1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1;
    alloc_req = 0;
    cdb_data = 0;
    m_reset();
    #1;
    chk("rst_count", count, 0);
    chk("rst_commit_en", commit_en, 0);
    chk("rst_commit_tag", commit_tag, 0);
    chk("rst_alloc_tag", alloc_tag, 1);
    chk("rst_alloc_ready", alloc_ready, 1);
    @(negedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    logic [5:0] ct;
    int r;
    do_reset();
    idle(1, 6'd1);
    for (int i = 1; i <= 3; i++) cyc(1, 5'(i), 0, 0, 6'd1, 6'd2);
    cyc(0, 0, 6'd2, 32'h0000AAAA, 6'd2, 6'd1);
    cyc(0, 0, 6'd1, 32'h00001111, 6'd2, 6'd1);
    idle(4, 6'd3);
    cyc(0, 0, 6'd3, 32'h00003333, 6'd3, 0);
    idle(3);
    do_reset();
    for (int i = 0; i < DEPTH; i++) cyc(1, 5'(i + 4), 0, 0, 0, 0);
    chk("full_count", count, DEPTH);
    cyc(1, 5'd31, 0, 0, 0, 0);
    cyc(0, 0, 6'd1, 32'h0BADF00D, 6'd1, 0);
    idle(2);
    cyc(1, 5'd9, 0, 0, 0, 0);
    chk("wrap_ready", alloc_ready, 0);
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, 5'(i + 10), 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 6'd3, 0);
    cyc(0, 0, 6'd3, 32'hDEADBEEF, 6'd3, 0);
    cyc(0, 0, 0, 0, 6'd3, 0);
    cyc(0, 0, 6'd0, 32'hFFFFFFFF, 6'd3, 6'd1);
    cyc(0, 0, 6'd9, 32'h99999999, 6'd9, 6'd3);
    cyc(0, 0, 6'd3, 32'h12345678, 6'd3, 0);
    idle(3, 6'd3);
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 5'(i + 20), 0, 0, 0, 0);
    cyc(0, 0, 6'd2, 32'h22222222, 0, 0);
    cyc(0, 0, 6'd3, 32'h33333333, 6'd2, 0);
    do_reset();
    idle(4, 6'd2);
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6 && order.size() > 0) ct = 6'(order[$urandom_range(0, order.size() - 1)]);
      else if (r < 8) ct = 0;
      else ct = 6'($urandom_range(0, 63));
      if (n < 500 && $urandom_range(0, 2) != 0) ct = 0;
      cyc(n < 500 ? $urandom_range(0, 9) != 0 : $urandom_range(0, 1) != 0, 5'($urandom), ct, $urandom,
          6'($urandom_range(0, 20)), 6'($urandom_range(0, 20)));
      if ($urandom_range(0, 299) == 0) do_reset();
    end
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
